// File: rtl/nes_poll_sequencer.sv
// Periodic NES controller poller: drives latch/shift-clock timing from a prescaled tick,
// shifts in the 8 active-low button bits and publishes a registered active-high button word.
module nes_poll_sequencer #(
   parameter int CLK_DIV     = 56,
   parameter int POLL_TICKS  = 14880,
   parameter int LATCH_TICKS = 11,
   parameter int HALF_TICKS  = 5
) (
   input  logic       inputclk,
   input  logic       reset_b,
   input  logic       enable,
   input  logic       data,
   output logic       clklatch,
   output logic       clkout,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right
);

   localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int POLL_W  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
   localparam int PHASE_N = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
   localparam int PHASE_W = (PHASE_N > 1) ? $clog2(PHASE_N) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
   localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_TICKS - 1);
   localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_TICKS - 1);
   localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_TICKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SLO,
      ST_SHI,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [POLL_W-1:0]    poll_q, poll_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           sr_q, sr_d;
   logic [7:0]           buttons_q, buttons_d;
   logic                 valid_q, valid_d;
   logic                 clklatch_q, clklatch_d;
   logic                 clkout_q, clkout_d;
   logic                 data_meta_q, data_sync_q;
   logic                 tick;

   assign tick    = (presc_q == PRESC_LAST);
   assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

   always_comb begin
      state_d   = state_q;
      poll_d    = poll_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      sr_d      = sr_q;
      buttons_d = buttons_q;
      valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!enable) begin
               poll_d = '0;
            end else if (tick) begin
               if (poll_q == POLL_LAST) begin
                  poll_d  = '0;
                  phase_d = '0;
                  state_d = ST_LATCH;
               end else begin
                  poll_d = poll_q + POLL_W'(1);
               end
            end
         end
         ST_LATCH: begin
            if (tick) begin
               if (phase_q == LATCH_LAST) begin
                  phase_d = '0;
                  idx_d   = '0;
                  state_d = ST_SLO;
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end
         ST_SLO: begin
            // Pad presents the current bit while clkout is low; grab it on the last tick.
            if (tick) begin
               if (phase_q == HALF_LAST) begin
                  phase_d     = '0;
                  sr_d[idx_q] = ~data_sync_q;
                  state_d     = (idx_q == 3'd7) ? ST_DONE : ST_SHI;
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end
         ST_SHI: begin
            if (tick) begin
               if (phase_q == HALF_LAST) begin
                  phase_d = '0;
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_SLO;
               end else begin
                  phase_d = phase_q + PHASE_W'(1);
               end
            end
         end
         ST_DONE: begin
            buttons_d = sr_q;
            valid_d   = 1'b1;
            poll_d    = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pad outputs are decoded from the next state so the pins come straight off flops.
   assign clklatch_d = (state_d == ST_LATCH);
   assign clkout_d   = (state_d == ST_SHI);

   always_ff @(posedge inputclk) begin
      if (!reset_b) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         poll_q      <= '0;
         phase_q     <= '0;
         idx_q       <= '0;
         sr_q        <= '0;
         buttons_q   <= '0;
         valid_q     <= 1'b0;
         clklatch_q  <= 1'b0;
         clkout_q    <= 1'b0;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         poll_q      <= poll_d;
         phase_q     <= phase_d;
         idx_q       <= idx_d;
         sr_q        <= sr_d;
         buttons_q   <= buttons_d;
         valid_q     <= valid_d;
         clklatch_q  <= clklatch_d;
         clkout_q    <= clkout_d;
         data_meta_q <= data;
         data_sync_q <= data_meta_q;
      end
   end

   assign clklatch = clklatch_q;
   assign clkout   = clkout_q;
   assign buttons  = buttons_q;
   assign valid    = valid_q;
   assign up       = buttons_q[4];
   assign down     = buttons_q[5];
   assign left     = buttons_q[6];
   assign right    = buttons_q[7];

endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer: a shift-register pad model feeds the DUT, a tick-position
// model predicts every output each cycle, and directed scenarios pin timing literals.
module tb_nes_poll_sequencer;

   localparam int CLK_DIV     = 4;
   localparam int POLL_TICKS  = 10;
   localparam int LATCH_TICKS = 3;
   localparam int HALF_TICKS  = 2;
   localparam int READ_TICKS  = LATCH_TICKS + 15 * HALF_TICKS;

   logic       inputclk = 1'b0;
   logic       reset_b  = 1'b0;
   logic       enable   = 1'b0;
   logic       data;
   logic       clklatch, clkout, valid, up, down, left, right;
   logic [7:0] buttons;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 inputclk = ~inputclk;
   always @(posedge inputclk) cyc <= cyc + 1;

   nes_poll_sequencer #(
      .CLK_DIV    (CLK_DIV),
      .POLL_TICKS (POLL_TICKS),
      .LATCH_TICKS(LATCH_TICKS),
      .HALF_TICKS (HALF_TICKS)
   ) dut (
      .inputclk(inputclk),
      .reset_b (reset_b),
      .enable  (enable),
      .data    (data),
      .clklatch(clklatch),
      .clkout  (clkout),
      .buttons (buttons),
      .valid   (valid),
      .up      (up),
      .down    (down),
      .left    (left),
      .right   (right)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pad: latch loads bit 0 (A); each rising clkout advances to the next button.
   logic [7:0] pad_buttons  = 8'h00;
   int         pad_idx      = 0;
   logic       pad_clk_prev = 1'b0;
   always @(negedge inputclk) begin
      if (clklatch === 1'b1) pad_idx = 0;
      else if (clkout === 1'b1 && pad_clk_prev !== 1'b1 && pad_idx < 7) pad_idx++;
      pad_clk_prev = clkout;
   end
   assign data = ~pad_buttons[pad_idx];

   // Model: position of the current read in ticks since the latch started.
   int         m_presc = 0, m_idle = 0, m_p = 0;
   bit         m_started = 0, m_busy = 0, m_done = 0, m_tick;
   logic [7:0] m_sr = 8'h00, m_buttons = 8'h00;
   logic       m_valid = 1'b0;

   always @(posedge inputclk) begin
      if (reset_b === 1'b0) begin
         m_started = 1; m_presc = 0; m_idle = 0; m_p = 0;
         m_busy = 0; m_done = 0; m_sr = 8'h00; m_buttons = 8'h00; m_valid = 1'b0;
      end else if (m_started) begin
         m_tick  = (m_presc == CLK_DIV - 1);
         m_presc = (m_presc + 1) % CLK_DIV;
         m_valid = 1'b0;
         if (m_done) begin
            m_buttons = m_sr; m_valid = 1'b1; m_done = 0; m_busy = 0; m_idle = 0;
         end else if (m_busy) begin
            if (m_tick) begin
               if (m_p >= LATCH_TICKS && ((m_p - LATCH_TICKS) / HALF_TICKS) % 2 == 0 &&
                   (m_p - LATCH_TICKS) % HALF_TICKS == HALF_TICKS - 1)
                  m_sr[(m_p - LATCH_TICKS) / (2 * HALF_TICKS)] = ~data;
               m_p++;
               if (m_p == READ_TICKS) m_done = 1;
            end
         end else if (!enable) begin
            m_idle = 0;
         end else if (m_tick) begin
            m_idle++;
            if (m_idle == POLL_TICKS) begin m_busy = 1; m_p = 0; end
         end
      end
   end

   always @(negedge inputclk) begin
      logic exp_latch, exp_clkout;
      if (m_started) begin
         exp_latch  = m_busy && !m_done && (m_p < LATCH_TICKS);
         exp_clkout = m_busy && !m_done && (m_p >= LATCH_TICKS) &&
                      (((m_p - LATCH_TICKS) / HALF_TICKS) % 2 == 1);
         chk("clklatch", clklatch, exp_latch);
         chk("clkout", clkout, exp_clkout);
         chk("valid", valid, m_valid);
         chk("buttons", buttons, m_buttons);
         chk("up", up, m_buttons[4]);
         chk("down", down, m_buttons[5]);
         chk("left", left, m_buttons[6]);
         chk("right", right, m_buttons[7]);
         chk("latch_and_clkout", clklatch & clkout, 1'b0);
      end
   end

   task automatic wait_read(input string tag, input logic [7:0] exp);
      int n;
      n = 0;
      do begin @(posedge inputclk); #1; n++; end while (valid !== 1'b1 && n < 3000);
      chk({tag, "_valid_seen"}, valid, 1'b1);
      chk({tag, "_buttons"}, buttons, exp);
      chk({tag, "_up"}, up, exp[4]);
      chk({tag, "_right"}, right, exp[7]);
   endtask

   task automatic wait_latch_rise(input string tag, output int t);
      int   n;
      logic prev;
      n = 0;
      do begin
         prev = clklatch;
         @(posedge inputclk); #1; n++;
      end while (!(clklatch === 1'b1 && prev !== 1'b1) && n < 3000);
      chk({tag, "_latch_seen"}, clklatch, 1'b1);
      t = cyc;
   endtask

   task automatic wait_clkout_rises(input string tag, input int k);
      int   seen, n;
      logic prev;
      seen = 0; n = 0;
      while (seen < k && n < 2000) begin
         prev = clkout;
         @(posedge inputclk); #1; n++;
         if (clkout === 1'b1 && prev !== 1'b1) seen++;
      end
      chk({tag, "_clkout_rises"}, seen, k);
   endtask

   task automatic first_latch_delay(input string tag);
      int n;
      n = 0;
      do begin @(posedge inputclk); #1; n++; end while (clklatch !== 1'b1 && n < 1000);
      chk({tag, "_first_latch_delay"}, n, 40);
   endtask

   initial begin
      int   n, w, pulses, hmin, hmax, hw, cnt, t0, t1, t2;
      logic prev;

      reset_b = 1'b0; enable = 1'b0; pad_buttons = 8'h00;
      repeat (3) @(posedge inputclk);
      #1;
      chk("reset_buttons", buttons, 8'h00);
      chk("reset_clklatch", clklatch, 1'b0);
      chk("reset_valid", valid, 1'b0);
      reset_b = 1'b1; enable = 1'b1;

      // Read 1: nothing pressed, with waveform timing pinned by hand.
      first_latch_delay("read1");
      w = 0;
      while (clklatch === 1'b1 && w < 100) begin @(posedge inputclk); #1; w++; end
      chk("read1_latch_width", w, 12);
      pulses = 0; hmin = 1000; hmax = 0; hw = 0; prev = 1'b0; n = 0;
      while (valid !== 1'b1 && n < 1000) begin
         @(posedge inputclk); #1; n++;
         if (clkout === 1'b1) hw++;
         else if (prev === 1'b1) begin
            pulses++;
            if (hw < hmin) hmin = hw;
            if (hw > hmax) hmax = hw;
            hw = 0;
         end
         prev = clkout;
      end
      chk("read1_clkout_pulses", pulses, 7);
      chk("read1_clkout_high_min", hmin, 8);
      chk("read1_clkout_high_max", hmax, 8);
      chk("read1_latchfall_to_valid", n, 121);
      chk("read1_valid", valid, 1'b1);
      chk("read1_buttons", buttons, 8'h00);

      pad_buttons = 8'h11;
      wait_read("read2_a_up", 8'h11);
      chk("read2_down", down, 1'b0);
      chk("read2_left", left, 1'b0);
      pad_buttons = 8'hFF;
      wait_read("read3_all", 8'hFF);
      pad_buttons = 8'h00;
      wait_read("read4_none", 8'h00);

      // Drop enable during the 4th shift-high phase: read completes, then silence.
      pad_buttons = 8'hA5;
      wait_latch_rise("read5", t0);
      wait_clkout_rises("read5", 4);
      enable = 1'b0;
      wait_read("read5_enable_drop", 8'hA5);
      cnt = 0;
      repeat (250) begin @(posedge inputclk); #1; if (clklatch === 1'b1 || valid === 1'b1) cnt++; end
      chk("disabled_activity", cnt, 0);

      // Reset while waiting to sample bit 5.
      enable = 1'b1; pad_buttons = 8'h3C;
      wait_latch_rise("read6", t0);
      wait_clkout_rises("read6", 5);
      n = 0;
      while (clkout === 1'b1 && n < 100) begin @(posedge inputclk); #1; n++; end
      reset_b = 1'b0;
      @(posedge inputclk); #1;
      chk("abort_clklatch", clklatch, 1'b0);
      chk("abort_clkout", clkout, 1'b0);
      chk("abort_valid", valid, 1'b0);
      chk("abort_buttons", buttons, 8'h00);
      reset_b = 1'b1; pad_buttons = 8'h5A;

      // Continuous polling: period is 43 ticks on the free-running tick grid.
      first_latch_delay("run");
      t0 = cyc;
      wait_read("run_read1", 8'h5A);
      wait_latch_rise("run_p1", t1);
      chk("run_period1", t1 - t0, 172);
      wait_read("run_read2", 8'h5A);
      wait_latch_rise("run_p2", t2);
      chk("run_period2", t2 - t1, 172);
      repeat (20) @(posedge inputclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
